// File: rtl/seven_seg_scanner.sv
//------------------------------------------------------------------------------
// Module     : seven_seg_scanner
// Description: Four-digit time-multiplexed seven-segment driver with
//              active-low anodes/segments. Optional blanking at the start of
//              every slot is enabled by defining SSD_GHOST_GUARD_EN.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       digit0_en_i,
  input  logic [3:0] digit0_i,
  input  logic       digit1_en_i,
  input  logic [3:0] digit1_i,
  input  logic       digit2_en_i,
  input  logic [3:0] digit2_i,
  input  logic       digit3_en_i,
  input  logic [3:0] digit3_i,
  output logic [3:0] anode_o,
  output logic [6:0] segments_o
);

  localparam int c_DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);

  // Parameter legality is enforced at elaboration so a bad build never synthesizes.
  if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_cfg
    $error("seven_seg_scanner: illegal REFRESH_DIV/BLANK_CYCLES");
  end

  logic [c_DIV_W-1:0] r_div;
  logic [1:0]         r_idx;
  logic               r_slot_en;
  logic [3:0]         r_slot_val;

  logic               w_tc;
  logic [1:0]         w_next_idx;
  logic               w_next_en;
  logic [3:0]         w_next_val;
  logic               w_guard;
  logic               w_lit;
  logic [6:0]         w_seg;

  assign w_tc       = (r_div == c_DIV_LAST);
  assign w_next_idx = r_idx + 2'd1;

  always_comb begin
    w_next_en  = 1'b0;
    w_next_val = 4'h0;
    case (w_next_idx)
      2'd0: begin w_next_en = digit0_en_i; w_next_val = digit0_i; end
      2'd1: begin w_next_en = digit1_en_i; w_next_val = digit1_i; end
      2'd2: begin w_next_en = digit2_en_i; w_next_val = digit2_i; end
      default: begin w_next_en = digit3_en_i; w_next_val = digit3_i; end
    endcase
  end

  // Divider, scan index and slot snapshot all move together on terminal count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div      <= '0;
      r_idx      <= 2'd0;
      r_slot_en  <= 1'b0;
      r_slot_val <= 4'h0;
    end else if (w_tc) begin
      r_div      <= '0;
      r_idx      <= w_next_idx;
      r_slot_en  <= w_next_en;
      r_slot_val <= w_next_val;
    end else begin
      r_div      <= r_div + c_DIV_W'(1);
    end
  end

`ifdef SSD_GHOST_GUARD_EN
  localparam logic [c_DIV_W-1:0] c_BLANK = c_DIV_W'(BLANK_CYCLES);
  assign w_guard = (r_div < c_BLANK);
`else
  assign w_guard = 1'b0;
`endif

  assign w_lit = r_slot_en && !w_guard;

  always_comb begin
    w_seg = 7'h7F;
    case (r_slot_val)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      default: w_seg = 7'h0E;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      anode_o    <= 4'hF;
      segments_o <= 7'h7F;
    end else if (w_lit) begin
      anode_o    <= ~(4'b0001 << r_idx);
      segments_o <= w_seg;
    end else begin
      anode_o    <= 4'hF;
      segments_o <= 7'h7F;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
//------------------------------------------------------------------------------
// Module     : tb_seven_seg_scanner
// Description: Self-checking bench; expected outputs come from a slot-time
//              model (edge count / REFRESH_DIV) plus per-slot input snapshots.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seven_seg_scanner;

  localparam int R = 8;
  localparam int B = 3;
`ifdef SSD_GHOST_GUARD_EN
  localparam int G = B;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en_v;
  logic [3:0] val_v [4];
  logic [3:0] anode;
  logic [6:0] segs;

  int checks = 0;
  int errors = 0;

  // Model state: rising edges since reset release, and the snapshot in force.
  int         n;
  logic       snap_en;
  logic [3:0] snap_val;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk_i(clk), .rst_i(rst),
    .digit0_en_i(en_v[0]), .digit0_i(val_v[0]),
    .digit1_en_i(en_v[1]), .digit1_i(val_v[1]),
    .digit2_en_i(en_v[2]), .digit2_i(val_v[2]),
    .digit3_en_i(en_v[3]), .digit3_i(val_v[3]),
    .anode_o(anode), .segments_o(segs)
  );

  task automatic check(input string tag, input logic [3:0] ea, input logic [6:0] es);
    checks++;
    assert (anode === ea) else begin
      errors++;
      $error("FAIL %s anode n=%0d observed=%h expected=%h", tag, n, anode, ea);
    end
    checks++;
    assert (segs === es) else begin
      errors++;
      $error("FAIL %s segments n=%0d observed=%h expected=%h", tag, n, segs, es);
    end
  endtask

  // One clock: outputs after edge n reflect slot state after edge n-1.
  task automatic step(input string tag);
    int m, slot, pos, d;
    @(posedge clk);
    n++;
    m    = n - 1;
    slot = m / R;
    pos  = m % R;
    d    = slot % 4;
    if (snap_en && pos >= G) begin
      exp_an  = 4'hF & ~(4'b0001 << d);
      exp_seg = seg_tab[snap_val];
    end else begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
    end
    if (n % R == 0) begin
      snap_en  = en_v[(n / R) % 4];
      snap_val = val_v[(n / R) % 4];
    end
    #1;
    check(tag, exp_an, exp_seg);
  endtask

  task automatic model_reset();
    n        = 0;
    snap_en  = 1'b0;
    snap_val = 4'h0;
  endtask

  initial begin
    int guard_cnt;
    rst      = 1'b1;
    en_v     = 4'hF;
    val_v[0] = 4'h0; val_v[1] = 4'h8; val_v[2] = 4'hA; val_v[3] = 4'hF;
    model_reset();
    #12;
    check("reset", 4'hF, 7'h7F);
    @(negedge clk);
    rst = 1'b0;

    // Hex decode on a fixed pattern over three frames (also covers wrap-around).
    for (int i = 0; i < 3 * 4 * R; i++) step("hex");

    // Digit 2 disabled.
    @(negedge clk);
    en_v = 4'b1011;
    for (int i = 0; i < 2 * 4 * R; i++) step("dis2");

    // Mid-slot change of digit 1 from 3 to 5.
    @(negedge clk);
    en_v = 4'hF;
    val_v[1] = 4'h3;
    guard_cnt = 0;
    while (!(((n / R) % 4 == 1) && (n / R >= 8) && (n % R == 3)) && guard_cnt < 10 * R) begin
      step("mid_wait");
      guard_cnt++;
    end
    checks++;
    assert (guard_cnt < 10 * R) else begin
      errors++;
      $error("FAIL mid_wait timeout observed=%0d expected<%0d", guard_cnt, 10 * R);
    end
    @(negedge clk);
    val_v[1] = 4'h5;
    for (int i = 0; i < 2 * 4 * R; i++) step("mid");

    // Randomized inputs changing at arbitrary points within slots.
    for (int i = 0; i < 50 * R; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, 3);
        val_v[k] = 4'($urandom_range(0, 15));
        en_v[k]  = ($urandom_range(0, 4) != 0);
      end
      step("rand");
    end

    // Asynchronous reset in mid-slot.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 4'hF, 7'h7F);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    en_v = 4'hF;
    for (int i = 0; i < 3 * 4 * R; i++) step("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
